rand_num_scheduler: RTL

//  Owns one Fibonacci LFSR and shares it round-robin among R requesters. Each grant advances the LFSR once.

---
 rtl/rand_num_scheduler.sv | 103 ++++++++++
 1 files changed

// File: rtl/rand_num_scheduler.sv
// rand_num_scheduler: one Fibonacci LFSR shared round-robin among R requesters,
// free-running on tick between grants, with seed loading.
module rand_num_scheduler #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
    parameter logic [WIDTH-1:0] SEED  = 4'b0001,
    parameter int              R     = 4,
    parameter int              RW    = $clog2(R)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [R-1:0]     req,
    output logic [R-1:0]     gnt,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_data,
    output logic [WIDTH-1:0] q,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, STEP, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [R-1:0]     gnt_q, gnt_d;
    logic             rnd_valid_q, rnd_valid_d;
    logic [WIDTH-1:0] rnd_data_q, rnd_data_d;
    logic [RW-1:0]    ptr_q, ptr_d, win_q, win_d, pick, idx;

    assign lfsr_nxt = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};

    // Descending scan so the requester closest after ptr is assigned last and wins
    always_comb begin
        pick = ptr_q;
        idx  = '0;
        for (int k = R; k >= 1; k--) begin
            idx = RW'((32'(ptr_q) + 32'(k)) % R);
            if (req[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        gnt_d       = gnt_q;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        case (state_q)
            IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed_in == '0) ? WIDTH'(1) : seed_in;
                end else if (|req) begin
                    win_d   = pick;
                    gnt_d   = R'(1) << pick;
                    state_d = STEP;
                end else if (tick) begin
                    lfsr_d = lfsr_nxt;
                end
            end
            STEP: begin
                lfsr_d      = lfsr_nxt;
                rnd_valid_d = 1'b1;
                rnd_data_d  = lfsr_nxt;
                state_d     = RESP;
            end
            RESP: begin
                ptr_d   = win_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= '0;
            ptr_q       <= RW'(R - 1);
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign q         = lfsr_q;
    assign busy      = (state_q != IDLE);
endmodule
